psum_pingpong_ctrl: RTL and testbench
=====================================

# psum_pingpong_ctrl

Sequencer for the two ping-pong psum SRAM banks (mem1/mem2) next to the corelet. It runs `num_kij` accumulation passes of `LEN_NIJ` psum vectors each. Every pass reads the previous partial sums from one bank while writing the updated sums into the other, and the bank roles swap between passes. After the last pass it dumps the finished bank to the output path. It replaces hand-driven `rchip`/`inst[4]`/`inst[6]` sequencing.

## Interface
Parameters:
- `LEN_NIJ`, 16, psum vectors per pass (addresses 0..LEN_NIJ-1)
- `ADDR_W`, 11, psum SRAM address width
- `KIJ_W`, 4, width of pass count

Ports:
- `clk` in 1: single clock; all state updates on its rising edge
- `reset` in 1: asynchronous, active-low (0 = reset)
- `start` in 1: one-cycle request to begin a job; sampled in IDLE only
- `num_kij` in KIJ_W: passes in the job; sampled with `start`
- `src_valid` in 1: corelet OFIFO holds a psum vector
- `src_rd` out 1: pop OFIFO this cycle
- `dump_ready` in 1: downstream accepts a dump vector
- `cen_mem1`, `wen_mem1` out 1 each: mem1 chip/write enables (active-low)
- `cen_mem2`, `wen_mem2` out 1 each: mem2 chip/write enables (active-low)
- `addr_mem1`, `addr_mem2` out ADDR_W each: bank addresses
- `rchip` out 1: 0 = read mem1/write mem2; 1 = read mem2/write mem1
- `first_pass` out 1: high during pass 0; SFU adds zero instead of SRAM data
- `dump_valid` out 1: final psum on bank Q is valid this cycle
- `kij_idx` out KIJ_W: current pass index
- `busy` out 1: high in any state except IDLE
- `done` out 1: one-cycle pulse at job end

## Operation
- States: IDLE, ACC, DRAIN, SWAP, DUMP, DONE.
- IDLE transitions:
  - `start` with `num_kij`≠0 → ACC, with `kij_idx`=0, `rchip`=0, `ptr`=0.
  - `start` with `num_kij`=0 is ignored.
  - `start` outside IDLE is ignored.
- ACC, issue stage:
  - If `src_valid` and `ptr`≤LEN_NIJ-1: assert `src_rd`, then `ptr`++.
  - In the same cycle, read-enable the read bank at `ptr` (CEN=0, WEN=1). Suppress this read when `first_pass`=1.
  - No `src_valid` → stall; no read is issued and `ptr` holds.
- ACC, write stage:
  - Registered `wr_v`/`wr_addr` copy the issue one cycle later.
  - When `wr_v`=1, the write bank is driven CEN=0, WEN=0 at `wr_addr`.
- Issue of address LEN_NIJ-1 → DRAIN. The DRAIN cycle performs the final write.
- DRAIN → DUMP if `kij_idx`=`num_kij`-1, otherwise → SWAP.
- SWAP (1 cycle): toggle `rchip`, `kij_idx`++, `ptr`=0, then → ACC.
- DUMP:
  - The finished bank is the last write bank: mem2 if `rchip`=0, mem1 if `rchip`=1.
  - If `dump_ready` and `ptr`≤LEN_NIJ-1: read that bank at `ptr`, then `ptr`++.
  - `dump_valid` asserts the next cycle.
  - The cycle after the last read → DONE.
- DONE: `done`=1 for one cycle, then → IDLE. `rchip` and `kij_idx` hold until the next `start`.
- Idle bank: CEN=1, WEN=1. A bank is never read and written in the same cycle.
- Width rules:
  - `ptr` is ADDR_W bits and is zero-extended onto the address.
  - `kij_idx` compares against `num_kij`-1 in KIJ_W bits.
  - `num_kij`=2^KIJ_W-1 is legal.

## Timing
- Reset (async, `reset`=0):
  - State → IDLE.
  - `src_rd`, `dump_valid`, `first_pass`, `busy`, `done`, `rchip` = 0; `kij_idx`, `ptr`, addresses = 0.
  - All CEN/WEN = 1; `wr_v` = 0.
- Reset mid-job aborts immediately with no partial write. The first rising edge after deassertion starts from IDLE.
- Read latency is 1: data for a read issued at edge N is on Q after edge N+1. The corresponding write occurs on edge N+1.
- Stall-free pass: LEN_NIJ issue cycles + 1 DRAIN + 1 SWAP.
- Stall-free job: `num_kij`·(LEN_NIJ+2) − 1 cycles before DUMP, then LEN_NIJ+1 DUMP cycles, then 1 DONE cycle.
- `src_valid` gaps only delay issue. Write order stays strictly increasing 0..LEN_NIJ-1.
- `dump_ready` deasserting stalls reads. `dump_valid` still completes for an already-issued read.

## Test plan
- Reset release, `num_kij`=1, LEN_NIJ=16, `src_valid` held 1 → `first_pass`=1, no mem1 reads; mem2 written at addr 0..15 on consecutive cycles; DUMP reads mem2 0..15; `done` pulses; 16 `dump_valid` cycles.
- `num_kij`=3, `src_valid` held 1 → `rchip` sequence 0,1,0; pass 1 reads mem2/writes mem1; pass 2 reads mem1/writes mem2; each write lags its read by exactly 1 cycle; DUMP reads mem2.
- `num_kij`=2, `src_valid` low on every 3rd cycle → `src_rd` never high while `src_valid` is low; exactly 16 writes per pass, in address order.
- During DUMP, `dump_ready` toggles 1,0,1,0 → reads advance only on ready cycles; 16 `dump_valid` total; `done` only after the last one.
- Assert `reset`=0 mid-pass-1 at `ptr`=7 → same cycle: all CEN=1, `busy`=0, `rchip`=0. A new `start` with `num_kij`=1 then runs cleanly from addr 0.
- `start` with `num_kij`=0, and `start` while busy → no state change; no `done`.

Source files
------------

// File: rtl/psum_pingpong_ctrl.sv
// Ping-pong psum SRAM sequencer. Runs num_kij accumulation passes of LEN_NIJ
// vectors. Each pass reads the old partial sums from one bank while the
// updated sums go into the other bank, and the banks swap roles between
// passes. After the last pass the finished bank is dumped to the output path.
module psum_pingpong_ctrl #(
  parameter int LEN_NIJ = 16,
  parameter int ADDR_W  = 11,
  parameter int KIJ_W   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [KIJ_W-1:0]  num_kij,
  input  logic              src_valid,
  output logic              src_rd,
  input  logic              dump_ready,
  output logic              cen_mem1,
  output logic              wen_mem1,
  output logic              cen_mem2,
  output logic              wen_mem2,
  output logic [ADDR_W-1:0] addr_mem1,
  output logic [ADDR_W-1:0] addr_mem2,
  output logic              rchip,
  output logic              first_pass,
  output logic              dump_valid,
  output logic [KIJ_W-1:0]  kij_idx,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACC,
    S_DRAIN,
    S_SWAP,
    S_DUMP,
    S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(LEN_NIJ - 1);

  state_t             state;
  logic [ADDR_W-1:0]  ptr;
  logic               wr_v;
  logic [ADDR_W-1:0]  wr_addr;
  logic [KIJ_W-1:0]   num_kij_r;

  logic acc_issue;
  logic dump_issue;

  // Issue qualifiers: a vector is popped / dumped only when the partner is
  // ready and the pass still has addresses left.
  assign acc_issue  = (state == S_ACC)  && src_valid  && (ptr <= LAST_ADDR);
  assign dump_issue = (state == S_DUMP) && dump_ready && (ptr <= LAST_ADDR);
  assign src_rd     = acc_issue;

  // Bank strobes: read bank follows the issue, write bank follows the
  // one-cycle-delayed issue, dump reads the bank written by the last pass.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch.
    cen_mem1  = 1'b1;
    wen_mem1  = 1'b1;
    addr_mem1 = '0;
    cen_mem2  = 1'b1;
    wen_mem2  = 1'b1;
    addr_mem2 = '0;

    if (acc_issue && !first_pass) begin
      if (!rchip) begin
        cen_mem1  = 1'b0;
        addr_mem1 = ptr;
      end else begin
        cen_mem2  = 1'b0;
        addr_mem2 = ptr;
      end
    end

    if (wr_v) begin
      if (!rchip) begin
        cen_mem2  = 1'b0;
        wen_mem2  = 1'b0;
        addr_mem2 = wr_addr;
      end else begin
        cen_mem1  = 1'b0;
        wen_mem1  = 1'b0;
        addr_mem1 = wr_addr;
      end
    end

    if (dump_issue) begin
      if (!rchip) begin
        cen_mem2  = 1'b0;
        addr_mem2 = ptr;
      end else begin
        cen_mem1  = 1'b0;
        addr_mem1 = ptr;
      end
    end
  end

  // Job sequencer: pass/address bookkeeping and registered status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      ptr        <= '0;
      wr_v       <= 1'b0;
      wr_addr    <= '0;
      num_kij_r  <= '0;
      rchip      <= 1'b0;
      kij_idx    <= '0;
      first_pass <= 1'b0;
      dump_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      wr_v       <= acc_issue;
      wr_addr    <= ptr;
      dump_valid <= dump_issue;
      done       <= 1'b0;

      case (state)
        S_IDLE: begin
          if (start && (num_kij != '0)) begin
            state      <= S_ACC;
            num_kij_r  <= num_kij;
            kij_idx    <= '0;
            rchip      <= 1'b0;
            ptr        <= '0;
            first_pass <= 1'b1;
            busy       <= 1'b1;
          end
        end

        S_ACC: begin
          if (acc_issue) begin
            ptr <= ptr + ADDR_W'(1);
            if (ptr == LAST_ADDR) state <= S_DRAIN;
          end
        end

        // Final write of the pass lands here; pick swap or dump.
        S_DRAIN: begin
          ptr        <= '0;
          first_pass <= 1'b0;
          if (kij_idx == (num_kij_r - KIJ_W'(1))) state <= S_DUMP;
          else                                    state <= S_SWAP;
        end

        S_SWAP: begin
          rchip   <= ~rchip;
          kij_idx <= kij_idx + KIJ_W'(1);
          ptr     <= '0;
          state   <= S_ACC;
        end

        // Leave one cycle after the last read so its dump_valid completes.
        S_DUMP: begin
          if (dump_issue) begin
            ptr <= ptr + ADDR_W'(1);
          end else if (ptr > LAST_ADDR) begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end

        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_psum_pingpong_ctrl.sv
// Scoreboard bench for psum_pingpong_ctrl. A job-level model lists, per bank,
// the ordered SRAM operations a job must produce; a negedge monitor pops and
// compares them as the DUT strobes the banks, and checks pop/issue timing.
module tb_psum_pingpong_ctrl;

  localparam int LEN    = 16;
  localparam int ADDR_W = 11;
  localparam int KIJ_W  = 4;

  typedef struct packed {
    logic              we_n;
    logic [ADDR_W-1:0] addr;
    logic              dump;
  } op_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [KIJ_W-1:0]  num_kij;
  logic              src_valid;
  logic              src_rd;
  logic              dump_ready;
  logic              cen_mem1, wen_mem1, cen_mem2, wen_mem2;
  logic [ADDR_W-1:0] addr_mem1, addr_mem2;
  logic              rchip, first_pass, dump_valid, busy, done;
  logic [KIJ_W-1:0]  kij_idx;

  psum_pingpong_ctrl #(.LEN_NIJ(LEN), .ADDR_W(ADDR_W), .KIJ_W(KIJ_W)) dut (
    .clk(clk), .reset(reset), .start(start), .num_kij(num_kij),
    .src_valid(src_valid), .src_rd(src_rd), .dump_ready(dump_ready),
    .cen_mem1(cen_mem1), .wen_mem1(wen_mem1),
    .cen_mem2(cen_mem2), .wen_mem2(wen_mem2),
    .addr_mem1(addr_mem1), .addr_mem2(addr_mem2),
    .rchip(rchip), .first_pass(first_pass), .dump_valid(dump_valid),
    .kij_idx(kij_idx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  op_t q1[$];
  op_t q2[$];
  int  wr_lag_q[$];
  int  dump_q[$];
  int  n_issue, n_dv, n_done, job_k, done_cyc;
  int  sv_mode = 0;
  int  dr_mode = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Job model: pass p reads mem1 when p is even, mem2 when odd (none on
  // pass 0), writes the other bank; the dump reads the last written bank.
  task automatic build_expect(input int k);
    op_t e;
    q1.delete(); q2.delete(); wr_lag_q.delete(); dump_q.delete();
    for (int p = 0; p < k; p++) begin
      for (int a = 0; a < LEN; a++) begin
        if (p > 0) begin
          e = '{we_n: 1'b1, addr: ADDR_W'(a), dump: 1'b0};
          if (p % 2 == 0) q1.push_back(e); else q2.push_back(e);
        end
        e = '{we_n: 1'b0, addr: ADDR_W'(a), dump: 1'b0};
        if (p % 2 == 0) q2.push_back(e); else q1.push_back(e);
      end
    end
    for (int a = 0; a < LEN; a++) begin
      e = '{we_n: 1'b1, addr: ADDR_W'(a), dump: 1'b1};
      if ((k - 1) % 2 == 0) q2.push_back(e); else q1.push_back(e);
    end
    n_issue = 0; n_dv = 0; n_done = 0; job_k = k;
  endtask

  task automatic check_op(input string bank, input op_t e, input logic wen,
                          input logic [ADDR_W-1:0] addr);
    int t;
    check({bank, "_wen"}, 32'(wen), 32'(e.we_n));
    check({bank, "_addr"}, 32'(addr), 32'(e.addr));
    if (!e.we_n) begin
      if (wr_lag_q.size() == 0) check({bank, "_wr_without_issue"}, 0, 1);
      else begin
        t = wr_lag_q.pop_front();
        check({bank, "_wr_lag"}, cyc, t + 1);
      end
    end else if (e.dump) begin
      check("dump_rd_ready", 32'(dump_ready), 1);
      dump_q.push_back(cyc);
    end else begin
      check({bank, "_rd_with_pop"}, 32'(src_rd), 1);
    end
  endtask

  // Monitor: compares every bank strobe against the scoreboard queues.
  always @(negedge clk) begin
    op_t e;
    int  pass, t;
    if (reset === 1'b1) begin
      if (src_rd) begin
        pass = n_issue / LEN;
        check("src_rd_needs_valid", 32'(src_valid), 1);
        if (n_issue >= job_k * LEN) check("src_rd_extra", n_issue, job_k * LEN);
        else begin
          check("first_pass", 32'(first_pass), 32'(pass == 0));
          check("rchip", 32'(rchip), pass % 2);
          check("kij_idx", 32'(kij_idx), pass);
        end
        wr_lag_q.push_back(cyc);
        n_issue++;
      end
      if (!cen_mem1) begin
        if (q1.size() == 0) check("mem1_unexpected_op", 0, 1);
        else begin e = q1.pop_front(); check_op("mem1", e, wen_mem1, addr_mem1); end
      end
      if (!cen_mem2) begin
        if (q2.size() == 0) check("mem2_unexpected_op", 0, 1);
        else begin e = q2.pop_front(); check_op("mem2", e, wen_mem2, addr_mem2); end
      end
      if (dump_valid) begin
        n_dv++;
        if (dump_q.size() == 0) check("dump_valid_without_read", 0, 1);
        else begin t = dump_q.pop_front(); check("dump_valid_lag", cyc, t + 1); end
      end
      if (done) begin
        n_done++;
        done_cyc = cyc;
        check("dump_valid_before_done", n_dv, LEN);
      end
    end
  end

  // Source and sink handshake drivers, updated just after each rising edge.
  initial begin
    int k = 0;
    forever begin
      @(posedge clk); #1;
      k++;
      case (sv_mode)
        0:       src_valid = 1'b1;
        1:       src_valid = (k % 3 != 2);
        default: src_valid = ($urandom_range(0, 3) != 0);
      endcase
      case (dr_mode)
        0:       dump_ready = 1'b1;
        1:       dump_ready = (k % 2 == 0);
        default: dump_ready = ($urandom_range(0, 2) != 0);
      endcase
    end
  end

  task automatic flush_reset();
    reset = 1'b0;
    q1.delete(); q2.delete(); wr_lag_q.delete(); dump_q.delete();
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
  endtask

  task automatic run_job(input int k, input bit timed, input bit inject);
    int t0;
    build_expect(k);
    @(posedge clk); #1;
    start = 1'b1; num_kij = KIJ_W'(k);
    @(posedge clk); #1;
    t0 = cyc;
    start = 1'b0; num_kij = KIJ_W'($urandom);
    for (int i = 0; i < 4000 && n_done == 0; i++) begin
      @(posedge clk); #1;
      start = inject && (i == 20);
      if (start) num_kij = KIJ_W'($urandom_range(1, 15));
    end
    start = 1'b0;
    if (n_done == 0) begin
      check("done_timeout", 0, 1);
      flush_reset();
      return;
    end
    if (timed) check("job_cycles", done_cyc - t0, 18 * k + 16);
    repeat (2) @(posedge clk); #1;
    check("done_pulses", n_done, 1);
    check("dump_valid_count", n_dv, LEN);
    check("issue_count", n_issue, k * LEN);
    check("mem1_ops_left", q1.size(), 0);
    check("mem2_ops_left", q2.size(), 0);
    check("busy_after_job", 32'(busy), 0);
    check("rchip_hold", 32'(rchip), (k - 1) % 2);
    check("kij_idx_hold", 32'(kij_idx), k - 1);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; num_kij = '0;
    src_valid = 1'b0; dump_ready = 1'b0;
    #3;
    check("rst_cen_mem1", 32'(cen_mem1), 1);
    check("rst_wen_mem1", 32'(wen_mem1), 1);
    check("rst_cen_mem2", 32'(cen_mem2), 1);
    check("rst_wen_mem2", 32'(wen_mem2), 1);
    check("rst_addr_mem1", 32'(addr_mem1), 0);
    check("rst_addr_mem2", 32'(addr_mem2), 0);
    check("rst_src_rd", 32'(src_rd), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_rchip", 32'(rchip), 0);
    check("rst_kij_idx", 32'(kij_idx), 0);
    check("rst_first_pass", 32'(first_pass), 0);
    check("rst_dump_valid", 32'(dump_valid), 0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;

    run_job(1, 1'b1, 1'b0);
    run_job(3, 1'b1, 1'b0);
    sv_mode = 1; run_job(2, 1'b0, 1'b0); sv_mode = 0;
    dr_mode = 1; run_job(1, 1'b0, 1'b0); dr_mode = 0;

    // Abort in pass 1 once ptr has reached 7.
    build_expect(2);
    @(posedge clk); #1; start = 1'b1; num_kij = 4'd2;
    @(posedge clk); #1; start = 1'b0;
    for (int i = 0; i < 500 && n_issue < LEN + 7; i++) begin
      @(negedge clk); #1;
    end
    check("abort_reached_ptr7", n_issue, LEN + 7);
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    check("abort_cen_mem1", 32'(cen_mem1), 1);
    check("abort_cen_mem2", 32'(cen_mem2), 1);
    check("abort_wen_mem1", 32'(wen_mem1), 1);
    check("abort_wen_mem2", 32'(wen_mem2), 1);
    check("abort_busy", 32'(busy), 0);
    check("abort_rchip", 32'(rchip), 0);
    check("abort_src_rd", 32'(src_rd), 0);
    flush_reset();
    run_job(1, 1'b1, 1'b0);

    // A zero-pass request must be ignored.
    n_done = 0;
    @(posedge clk); #1; start = 1'b1; num_kij = '0;
    @(posedge clk); #1; start = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      check("zero_kij_busy", 32'(busy), 0);
    end
    check("zero_kij_no_done", n_done, 0);

    // Randomised handshakes, including the largest pass count and stray
    // start pulses while busy.
    sv_mode = 2; dr_mode = 2;
    run_job(15, 1'b0, 1'b1);
    for (int j = 0; j < 5; j++) run_job($urandom_range(1, 6), 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
